// File: rtl/mult_accumulator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_accumulator_if : product-stream in / accumulated-sum out handshake bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface mult_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_accumulator : signed product-stream accumulator with optional clamping
// Rev 1.0
// ---------------------------------------------------------------------------
module mult_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16,
  parameter bit SAT    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  mult_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               beat;

  assign prod_ext = ACC_W'($signed(bus.in_prod));
  assign sum      = acc_q + prod_ext;
  // Overflow only when both operands share a sign and the sum's sign differs.
  assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign acc_next = (add_ovf && SAT) ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
  assign cnt_inc  = (&count_q) ? count_q : count_q + CNT_W'(1);

  assign bus.in_ready  = (state_q == ACCUM) && rst_n;
  assign beat          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      // A beat coinciding with clear becomes the first beat of a new packet.
      if (state_q == ACCUM && beat) begin
        acc_d   = prod_ext;
        count_d = CNT_W'(1);
        if (bus.in_last) begin
          state_d     = HOLD;
          out_acc_d   = prod_ext;
          out_count_d = CNT_W'(1);
          out_ovf_d   = 1'b0;
        end
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat) begin
            acc_d   = acc_next;
            count_d = cnt_inc;
            ovf_d   = ovf_q | add_ovf;
            if (bus.in_last) begin
              state_d     = HOLD;
              out_acc_d   = acc_next;
              out_count_d = cnt_inc;
              out_ovf_d   = ovf_q | add_ovf;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_accumulator : directed + random bench for clamping and wrapping builds
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_accumulator;

  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;
  localparam longint SPAN = 64'sd1099511627776;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  mult_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) bus_s ();
  mult_accumulator_if #(.PROD_W(32), .ACC_W(40), .CNT_W(16)) bus_w ();

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(16), .SAT(1'b1)) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_s.slave)
  );

  mult_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(16), .SAT(1'b0)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_w.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: index 1 = clamping build, index 0 = wrapping build.
  bit     m_hold;
  longint m_acc [2];
  bit     m_ovf [2];
  int     m_cnt;
  longint m_oacc [2];
  bit     m_oovf [2];
  int     m_ocnt;
  int     n_deliv;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit l, input bit r, input bit c);
    bus_s.in_valid = v; bus_s.in_prod = p; bus_s.in_last = l; bus_s.out_ready = r;
    bus_w.in_valid = v; bus_w.in_prod = p; bus_w.in_last = l; bus_w.out_ready = r;
    clear = c;
  endtask

  task automatic model_zero();
    m_hold = 1'b0;
    m_cnt  = 0;
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_ovf[s] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("in_ready_sat",   64'(bus_s.in_ready),  64'(!m_hold));
    check_eq("in_ready_wrap",  64'(bus_w.in_ready),  64'(!m_hold));
    check_eq("out_valid_sat",  64'(bus_s.out_valid), 64'(m_hold));
    check_eq("out_valid_wrap", 64'(bus_w.out_valid), 64'(m_hold));
    if (m_hold) begin
      check_eq("out_acc_sat",    64'(bus_s.out_acc),   64'(m_oacc[1][39:0]));
      check_eq("out_acc_wrap",   64'(bus_w.out_acc),   64'(m_oacc[0][39:0]));
      check_eq("out_count_sat",  64'(bus_s.out_count), 64'(m_ocnt));
      check_eq("out_count_wrap", 64'(bus_w.out_count), 64'(m_ocnt));
      check_eq("out_ovf_sat",    64'(bus_s.out_ovf),   64'(m_oovf[1]));
      check_eq("out_ovf_wrap",   64'(bus_w.out_ovf),   64'(m_oovf[0]));
    end
  endtask

  task automatic finish_packet();
    m_hold = 1'b1;
    m_ocnt = m_cnt;
    for (int s = 0; s < 2; s++) begin
      m_oacc[s] = m_acc[s];
      m_oovf[s] = m_ovf[s];
    end
  endtask

  // One clock: check current outputs, predict the edge, advance to 1 time unit past it.
  task automatic cycle(input bit v, input logic [31:0] p, input bit l, input bit r, input bit c);
    longint pl;
    longint exact;
    bit     beat;
    drive(v, p, l, r, c);
    #1;
    check_outputs();
    pl   = longint'($signed(p));
    beat = v && !m_hold;
    if (c) begin
      model_zero();
      if (beat) begin
        m_cnt = 1;
        for (int s = 0; s < 2; s++) m_acc[s] = pl;
        if (l) finish_packet();
      end
    end else if (m_hold) begin
      if (r) begin
        model_zero();
        n_deliv++;
      end
    end else if (beat) begin
      for (int s = 0; s < 2; s++) begin
        exact = m_acc[s] + pl;
        if (exact > MAXV || exact < MINV) begin
          m_ovf[s] = 1'b1;
          if (s == 1) begin
            exact = (exact > MAXV) ? MAXV : MINV;
          end else begin
            exact = exact & 64'h0000_00FF_FFFF_FFFF;
            if (exact > MAXV) exact = exact - SPAN;
          end
        end
        m_acc[s] = exact;
      end
      m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      if (l) finish_packet();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready_sat",  64'(bus_s.in_ready), 64'd0);
    check_eq("rst_in_ready_wrap", 64'(bus_w.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_zero();
    for (int s = 0; s < 2; s++) begin
      m_oacc[s] = 0;
      m_oovf[s] = 1'b0;
    end
    m_ocnt = 0;
    check_eq("rst_out_valid", 64'(bus_s.out_valid), 64'd0);
    check_eq("rst_out_acc",   64'(bus_s.out_acc),   64'd0);
    check_eq("rst_out_count", 64'(bus_s.out_count), 64'd0);
    check_eq("rst_out_ovf",   64'(bus_s.out_ovf),   64'd0);
    check_eq("rst_out_acc_w", 64'(bus_w.out_acc),   64'd0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, r, 1'b0);
  endtask

  int deliv_before;

  initial begin
    n_deliv = 0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Basic: 6, -4, 10 -> 12 / 3
    cycle(1'b1, 32'd6, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, -32'sd4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd10, 1'b1, 1'b1, 1'b0);
    check_eq("basic_acc", 64'(bus_s.out_acc), 64'd12);
    idle(2, 1'b1);

    // Backpressure with a waiting beat of 7
    cycle(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'd200, 1'b1, 1'b0, 1'b0);
    check_eq("bp_acc", 64'(bus_s.out_acc), 64'd300);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'd7, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'd7, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'd7, 1'b1, 1'b1, 1'b0);
    check_eq("bp_next_acc", 64'(bus_s.out_acc), 64'd7);
    idle(2, 1'b1);

    // Saturation / wrap at both rails
    for (int n = 256; n <= 257; n++) begin
      for (int i = 1; i <= n; i++) cycle(1'b1, 32'h7FFF_FFFF, (i == n), 1'b0, 1'b0);
      idle(2, 1'b1);
    end
    check_eq("pos_clamp_held", 64'(bus_s.out_acc), 64'h7F_FFFF_FFFF);
    for (int i = 1; i <= 257; i++) cycle(1'b1, 32'h8000_0000, (i == 257), 1'b0, 1'b0);
    check_eq("neg_clamp", 64'(bus_s.out_acc), 64'h80_0000_0000);
    idle(2, 1'b1);

    // Clear with a simultaneous beat, then clear while holding
    cycle(1'b1, 32'd50, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd60, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd5, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'd9, 1'b1, 1'b0, 1'b0);
    check_eq("clr_acc", 64'(bus_s.out_acc), 64'd14);
    idle(2, 1'b1);
    cycle(1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    deliv_before = n_deliv;
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    check_eq("clr_hold_no_delivery", 64'(n_deliv), 64'(deliv_before));

    // Reset mid-packet
    cycle(1'b1, 32'd11, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd22, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd33, 1'b0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_acc", 64'(bus_s.out_acc), 64'd1);
    idle(2, 1'b1);

    // Multiplier products: -300*200, 123*456
    cycle(1'b1, 32'(-60000), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'd56088, 1'b1, 1'b0, 1'b0);
    check_eq("mult_acc", 64'(bus_s.out_acc), 64'hFF_FFFF_F0B8);
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 6) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
